// File: rtl/pulse_meter.sv
// Pulse-train meter: reports high width and period (in clock cycles) of a synchronised input.
// Optional glitch filter enabled by defining PULSE_METER_GLITCH_FILTER_EN (requires FILTER_LEN >= 2).
module pulse_meter #(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal_in,
    input  logic             enable,
    output logic [WIDTH-1:0] high_width,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             overflow,
    output logic             level
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic sync1, sync2, s, s_d, rise, fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
            s_d   <= s;
        end
    end

`ifdef PULSE_METER_GLITCH_FILTER_EN
    // Previous synchroniser samples, newest in bit 0; s follows sync2 only once all agree.
    logic [FILTER_LEN-2:0] hist;
    logic                  agree;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist <= '0;
        end else begin
            hist[0] <= sync2;
            for (int unsigned i = 1; i < FILTER_LEN - 1; i++)
                hist[i] <= hist[i-1];
        end
    end

    assign agree = sync2 ? (&hist) : ~(|hist);
    assign s     = agree ? sync2 : s_d;
`else
    assign s = sync2;
`endif

    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;
    assign level = s;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n, inc, hw, hw_n;
    logic [WIDTH-1:0] high_width_n, period_n;
    logic             sat, sat_n, overflow_n, valid_n;

    assign inc = (cnt == CMAX) ? CMAX : cnt + ONE;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        hw_n         = hw;
        sat_n        = sat;
        high_width_n = high_width;
        period_n     = period;
        overflow_n   = overflow;
        valid_n      = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            sat_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = HIGH;
                        cnt_n   = ONE;
                        sat_n   = 1'b0;
                    end
                end
                HIGH: begin
                    cnt_n = inc;
                    sat_n = sat | (inc == CMAX);
                    if (fall) begin
                        hw_n    = cnt;
                        state_n = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_n     = cnt;
                        high_width_n = hw;
                        overflow_n   = sat;
                        valid_n      = 1'b1;
                        cnt_n        = ONE;
                        sat_n        = 1'b0;
                        state_n      = HIGH;
                    end else begin
                        cnt_n = inc;
                        sat_n = sat | (inc == CMAX);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hw         <= '0;
            sat        <= 1'b0;
            high_width <= '0;
            period     <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hw         <= hw_n;
            sat        <= sat_n;
            high_width <= high_width_n;
            period     <= period_n;
            overflow   <= overflow_n;
            valid      <= valid_n;
        end
    end

endmodule
